// File: rtl/otter_iobus_timer_if.sv
// OTTER IOBUS responder interface: CPU-driven address/data/strobe,
// read data returned to the CPU.
interface otter_iobus_timer_if;
  logic [31:0] IOBUS_ADDR;
  logic [31:0] IOBUS_OUT;
  logic        IOBUS_WR;
  logic [31:0] IOBUS_IN;

  modport master (
    output IOBUS_ADDR,
    output IOBUS_OUT,
    output IOBUS_WR,
    input  IOBUS_IN
  );

  modport slave (
    input  IOBUS_ADDR,
    input  IOBUS_OUT,
    input  IOBUS_WR,
    output IOBUS_IN
  );
endinterface

// File: rtl/otter_iobus_timer.sv
// Memory-mapped countdown timer on the OTTER IOBUS with prescaler,
// auto-reload and sticky expiry; OTTER_TIMER_EXPCNT_EN adds EXPCNT.
module otter_iobus_timer #(
  parameter logic [31:0] BASE_ADDR  = 32'h1100_0100,
  parameter int          PRESCALE_W = 16
) (
  input  logic              CLK,
  input  logic              RESET,
  otter_iobus_timer_if.slave bus,
  output logic              INTR
);

  localparam logic [2:0] REG_CTRL     = 3'd0;
  localparam logic [2:0] REG_LOAD     = 3'd1;
  localparam logic [2:0] REG_COUNT    = 3'd2;
  localparam logic [2:0] REG_STATUS   = 3'd3;
  localparam logic [2:0] REG_PRESCALE = 3'd4;
  localparam logic [2:0] REG_EXPCNT   = 3'd5;

  logic                  hit;
  logic [2:0]            sel;
  logic                  wrHit;
  logic                  ctrlWr;
  logic                  loadWr;
  logic                  countWr;
  logic                  statusWr;
  logic                  prescWr;

  logic                  en;
  logic                  autoReload;
  logic                  irqEn;
  logic                  expired;
  logic [31:0]           load;
  logic [31:0]           count;
  logic [PRESCALE_W-1:0] prescale;
  logic [PRESCALE_W-1:0] presc;

  logic                  rawTick;
  logic                  tick;
  logic                  expire;
  logic                  enRise;
  logic [31:0]           rdata;
  logic                  unused;

  assign hit   = bus.IOBUS_ADDR[31:5] == BASE_ADDR[31:5];
  assign sel   = bus.IOBUS_ADDR[4:2];
  assign wrHit = bus.IOBUS_WR && hit;

  assign ctrlWr   = wrHit && (sel == REG_CTRL);
  assign loadWr   = wrHit && (sel == REG_LOAD);
  assign countWr  = wrHit && (sel == REG_COUNT);
  assign statusWr = wrHit && (sel == REG_STATUS);
  assign prescWr  = wrHit && (sel == REG_PRESCALE);

  assign unused = &{1'b0, bus.IOBUS_ADDR[1:0]};

  // A CTRL write that drops EN swallows a tick landing in the same cycle
  assign rawTick = en && (presc == prescale);
  assign tick    = rawTick
                && !(ctrlWr && !bus.IOBUS_OUT[0]);
  assign expire  = tick && !countWr
                && (count == 32'd1);
  assign enRise  = ctrlWr && bus.IOBUS_OUT[0] && !en;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      presc <= '0;
    end else if (enRise || prescWr) begin
      presc <= '0;
    end else if (en) begin
      presc <= rawTick ? '0
                       : presc + PRESCALE_W'(1);
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      en         <= 1'b0;
      autoReload <= 1'b0;
      irqEn      <= 1'b0;
    end else if (ctrlWr) begin
      en         <= bus.IOBUS_OUT[0];
      autoReload <= bus.IOBUS_OUT[1];
      irqEn      <= bus.IOBUS_OUT[2];
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      load <= '0;
    end else if (loadWr) begin
      load <= bus.IOBUS_OUT;
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      prescale <= '0;
    end else if (prescWr) begin
      prescale <= bus.IOBUS_OUT[PRESCALE_W-1:0];
    end
  end

  // CPU write beats the countdown; zero means idle
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      count <= '0;
    end else if (countWr) begin
      count <= bus.IOBUS_OUT;
    end else if (tick) begin
      if (count == 32'd1) begin
        count <= autoReload ? load : 32'd0;
      end else if (count != 32'd0) begin
        count <= count - 32'd1;
      end
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      expired <= 1'b0;
    end else if (expire) begin
      expired <= 1'b1;
    end else if (statusWr && bus.IOBUS_OUT[0]) begin
      expired <= 1'b0;
    end
  end

`ifdef OTTER_TIMER_EXPCNT_EN
  logic       expCntWr;
  logic [7:0] expCnt;

  assign expCntWr = wrHit && (sel == REG_EXPCNT);

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      expCnt <= '0;
    end else if (expCntWr) begin
      expCnt <= {7'd0, expire};
    end else if (expire && expCnt != 8'hFF) begin
      expCnt <= expCnt + 8'd1;
    end
  end
`endif

  always_comb begin
    rdata = '0;
    if (hit) begin
      unique case (sel)
        REG_CTRL:
          rdata = {29'd0, irqEn, autoReload, en};
        REG_LOAD:
          rdata = load;
        REG_COUNT:
          rdata = count;
        REG_STATUS:
          rdata = {31'd0, expired};
        REG_PRESCALE:
          rdata = 32'(prescale);
        REG_EXPCNT:
`ifdef OTTER_TIMER_EXPCNT_EN
          rdata = {24'd0, expCnt};
`else
          rdata = '0;
`endif
        default:
          rdata = '0;
      endcase
    end
  end

  assign bus.IOBUS_IN = rdata;
  assign INTR         = expired && irqEn;

endmodule

// File: tb/tb_otter_iobus_timer.sv
// Directed and randomized checks of otter_iobus_timer against a
// cycle-level behavioural model of the register rules.
module tb_otter_iobus_timer;

  localparam logic [31:0] BASE = 32'h1100_0100;

  logic CLK = 1'b0;
  logic RESET = 1'b1;
  logic INTR;

  always #5 CLK = ~CLK;

  otter_iobus_timer_if bus ();

  otter_iobus_timer #(
    .BASE_ADDR (BASE),
    .PRESCALE_W(16)
  ) dut (
    .CLK  (CLK),
    .RESET(RESET),
    .bus  (bus),
    .INTR (INTR)
  );

  int tests = 0;
  int fails = 0;

  bit          mEn, mAr, mIrq, mExp;
  int unsigned mLoad, mCount, mPre, mPresc, mXc;

  task automatic mReset();
    mEn = 0; mAr = 0; mIrq = 0; mExp = 0;
    mLoad = 0; mCount = 0; mPre = 0;
    mPresc = 0; mXc = 0;
  endtask

  function automatic logic [31:0] mRead(logic [31:0] a);
    logic [31:0] r;
    r = 32'd0;
    if (a[31:5] == BASE[31:5]) begin
      case (a[4:2])
        3'd0: r = {29'd0, mIrq, mAr, mEn};
        3'd1: r = mLoad;
        3'd2: r = mCount;
        3'd3: r = {31'd0, mExp};
        3'd4: r = mPre;
`ifdef OTTER_TIMER_EXPCNT_EN
        3'd5: r = mXc;
`endif
        default: r = 32'd0;
      endcase
    end
    return r;
  endfunction

  // One clock edge of the timer, from the register rules
  task automatic mStep(bit w, logic [31:0] a, logic [31:0] d);
    bit hit, we, tick, ex;
    int off;
    hit  = (a[31:5] == BASE[31:5]);
    off  = int'(a[4:2]);
    we   = w && hit;
    tick = mEn && (mPresc == mPre);
    ex   = 0;
    if (we && ((off == 0 && d[0] && !mEn) || off == 4))
      mPresc = 0;
    else if (mEn)
      mPresc = (mPresc == mPre) ? 0 : mPresc + 1;
    if (we && off == 0 && !d[0]) tick = 0;
    if (we && off == 2) begin
      mCount = d;
    end else if (tick && mCount == 1) begin
      ex = 1;
      mCount = mAr ? mLoad : 0;
    end else if (tick && mCount > 1) begin
      mCount = mCount - 1;
    end
    if (ex) mExp = 1;
    else if (we && off == 3 && d[0]) mExp = 0;
    if (we && off == 5) mXc = ex;
    else if (ex && mXc < 255) mXc = mXc + 1;
    if (we && off == 0) {mIrq, mAr, mEn} = d[2:0];
    if (we && off == 1) mLoad = d;
    if (we && off == 4) mPre = d & 32'h0000_FFFF;
  endtask

  task automatic chk(string tag, logic [31:0] got,
                     logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic drive(logic [31:0] a, logic [31:0] d, bit w);
    bus.IOBUS_ADDR = a;
    bus.IOBUS_OUT  = d;
    bus.IOBUS_WR   = w;
  endtask

  task automatic step();
    @(posedge CLK);
    mStep(bus.IOBUS_WR, bus.IOBUS_ADDR, bus.IOBUS_OUT);
    #1;
    chk("intr", {31'd0, INTR}, {31'd0, mExp & mIrq});
  endtask

  task automatic wr(int off, logic [31:0] d);
    drive(BASE + 32'(off * 4), d, 1'b1);
    step();
    bus.IOBUS_WR = 1'b0;
  endtask

  task automatic idle(int n);
    bus.IOBUS_WR = 1'b0;
    repeat (n) step();
  endtask

  task automatic rdK(string tag, int off, logic [31:0] exp);
    drive(BASE + 32'(off * 4), 32'd0, 1'b0);
    #1;
    chk(tag, bus.IOBUS_IN, exp);
  endtask

  logic [31:0] ra, rd;
  int          roff;
  bit          rw;

  initial begin
    drive(BASE, 32'd0, 1'b0);
    mReset();
    repeat (2) @(posedge CLK);
    #1;
    RESET = 1'b0;
    rdK("rst_ctrl", 0, 32'd0);
    rdK("rst_count", 2, 32'd0);
    rdK("rst_status", 3, 32'd0);
    chk("rst_intr", {31'd0, INTR}, 32'd0);

    // async reset mid-count
    wr(2, 32'h20);
    wr(0, 32'h1);
    idle(5);
    rdK("run_count", 2, 32'h1B);
    #1;
    RESET = 1'b1;
    mReset();
    #1;
    rdK("arst_count", 2, 32'd0);
    rdK("arst_ctrl", 0, 32'd0);
    rdK("arst_status", 3, 32'd0);
    chk("arst_intr", {31'd0, INTR}, 32'd0);
    RESET = 1'b0;
    idle(3);
    rdK("arst_idle", 2, 32'd0);

    // decode
    drive(BASE + 32'h20, 32'h7, 1'b1);
    step();
    drive(BASE + 32'h20, 32'h0, 1'b0);
    #1;
    chk("miss_rd", bus.IOBUS_IN, 32'd0);
    rdK("miss_ctrl", 0, 32'd0);
    wr(6, 32'hFFFF_FFFF);
    rdK("off6", 6, 32'd0);
    wr(4, 32'hFFFF_FFFF);
    rdK("presc_w", 4, 32'h0000_FFFF);
    wr(4, 32'd0);

    // one-shot
    wr(2, 32'd3);
    wr(0, 32'h5);
    idle(2);
    rdK("os_early", 3, 32'd0);
    idle(1);
    rdK("os_exp", 3, 32'd1);
    chk("os_intr", {31'd0, INTR}, 32'd1);
    rdK("os_cnt", 2, 32'd0);
    idle(4);
    rdK("os_hold", 2, 32'd0);
    wr(3, 32'd1);
    chk("os_w1c_intr", {31'd0, INTR}, 32'd0);

    // auto-reload with prescale
    wr(0, 32'd0);
    wr(3, 32'd1);
    wr(1, 32'd4);
    wr(2, 32'd4);
    wr(4, 32'd2);
    wr(0, 32'h3);
    idle(11);
    rdK("ar_early", 3, 32'd0);
    idle(1);
    rdK("ar_exp", 3, 32'd1);
    rdK("ar_reload", 2, 32'd4);
    wr(3, 32'd1);
    rdK("ar_w1c", 3, 32'd0);
    idle(10);
    rdK("ar_early2", 3, 32'd0);
    idle(1);
    rdK("ar_exp2", 3, 32'd1);

    // collisions
    wr(0, 32'd0);
    wr(4, 32'd0);
    wr(3, 32'd1);
    wr(2, 32'd1);
    wr(0, 32'd1);
    wr(2, 32'd9);
    rdK("col_cnt", 2, 32'd9);
    rdK("col_noexp", 3, 32'd0);
    wr(0, 32'd0);
    wr(2, 32'd1);
    wr(0, 32'd1);
    wr(3, 32'd1);
    rdK("col_setwins", 3, 32'd1);

    // expiry counter
    wr(0, 32'd0);
    wr(3, 32'd1);
    wr(5, 32'd0);
    wr(1, 32'd1);
    wr(2, 32'd1);
    wr(0, 32'h3);
    idle(300);
`ifdef OTTER_TIMER_EXPCNT_EN
    rdK("xc_sat", 5, 32'd255);
    wr(5, 32'd0);
    wr(0, 32'd0);
    rdK("xc_clr_exp", 5, 32'd1);
    wr(5, 32'hA5);
    rdK("xc_clr", 5, 32'd0);
`else
    rdK("xc_off", 5, 32'd0);
    wr(5, 32'd0);
    wr(0, 32'd0);
    rdK("xc_off2", 5, 32'd0);
`endif

    // randomized traffic against the model
    wr(3, 32'd1);
    for (int i = 0; i < 400; i++) begin
      roff = $urandom_range(0, 7);
      ra = (($urandom_range(0, 9) == 0) ? BASE + 32'h20 : BASE)
         + 32'(roff * 4);
      rw = ($urandom_range(0, 3) == 0);
      case (roff)
        0: rd = $urandom_range(0, 7);
        1, 2: rd = $urandom_range(0, 6);
        3: rd = $urandom_range(0, 1);
        4: rd = $urandom_range(0, 3);
        default: rd = $urandom;
      endcase
      drive(ra, rd, rw);
      #1;
      chk("rnd_rd", bus.IOBUS_IN, mRead(ra));
      step();
    end
    bus.IOBUS_WR = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
